// File: rtl/sha2_pkg.sv
// sha2_pkg: shared definitions for the SHA-2 controller byte path.
//   state_e       - digest serializer FSM states
//   DIGEST_W      - digest width in bits
//   ASCII_*       - characters used by the hex / line-ending encoder
//   nibble_to_hex - 4-bit value to lowercase ASCII hex character
package sha2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_FINISH    = 3'd4
   } state_e;

   localparam int         DIGEST_W   = 256;
   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_A_LC = 8'h61;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   // 0..9 -> '0'..'9', 10..15 -> 'a'..'f'
   function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
      logic [7:0] v;
      if (nib < 4'd10) begin
         v = ASCII_0 + {4'd0, nib};
      end else begin
         v = ASCII_A_LC + {4'd0, nib - 4'd10};
      end
      return v;
   endfunction

endpackage

// File: rtl/digest_tx_serializer.sv
// digest_tx_serializer: captures a 256-bit digest on start_i and hands it to
// a UART transmitter one byte at a time, MSB byte first, as raw bytes or as
// lowercase ASCII hex, optionally followed by CR LF.
// Parameters: HEX_MODE (1 = 64 hex chars, 0 = 32 raw bytes),
//             APPEND_CRLF (1 = append 0x0D 0x0A).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             one-cycle request, accepted only when idle
//   digest_i            digest, bits [255:248] are byte 0
//   is_transmitting_i   UART busy status
//   transmit_o          one-cycle strobe, tx_byte_o valid while high
//   tx_byte_o           byte to send, held until the next strobe
//   busy_o              high from acceptance until the final byte completes
//   done_o              one-cycle pulse after the final byte has left the UART
module digest_tx_serializer
   import sha2_pkg::*;
#(
   parameter int HEX_MODE    = 1,
   parameter int APPEND_CRLF = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [DIGEST_W-1:0] digest_i,
   input  logic                is_transmitting_i,
   output logic                transmit_o,
   output logic [7:0]          tx_byte_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam int         NUM_DIG   = (HEX_MODE != 0) ? 64 : 32;
   localparam int         NUM_BYTES = NUM_DIG + ((APPEND_CRLF != 0) ? 2 : 0);
   localparam logic [6:0] LAST_IDX  = 7'(NUM_BYTES - 1);
   // index of the first byte after the digest body (the CR, when enabled)
   localparam logic [6:0] DIG_END   = 7'(NUM_DIG);
   localparam logic       HEX       = (HEX_MODE != 0);

   state_e              r_state;
   state_e              w_next_state;
   logic [DIGEST_W-1:0] r_shift;
   logic [DIGEST_W-1:0] w_next_shift;
   logic [6:0]          r_idx;
   logic [6:0]          w_next_idx;
   logic                w_shift_now;
   logic [7:0]          w_enc_byte;
   logic                r_transmit;
   logic [7:0]          r_tx_byte;
   logic                r_busy;
   logic                r_done;

   // Next state, shift register and byte index
   always_comb begin
      w_next_state = r_state;
      w_next_shift = r_shift;
      w_next_idx   = r_idx;
      // a digest byte is fully consumed after every raw byte, or after the
      // low-nibble character in hex mode; CRLF indices never shift
      w_shift_now  = (r_idx < DIG_END) && (!HEX || r_idx[0]);
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_next_state = ST_SEND;
               w_next_shift = digest_i;
               w_next_idx   = 7'd0;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_SEND: begin
            w_next_state = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (is_transmitting_i) begin
               w_next_state = ST_WAIT_DONE;
            end else begin
               w_next_state = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_DONE: begin
            if (!is_transmitting_i) begin
               if (r_idx == LAST_IDX) begin
                  w_next_state = ST_FINISH;
               end else begin
                  w_next_state = ST_SEND;
                  w_next_idx   = r_idx + 7'd1;
                  if (w_shift_now) begin
                     w_next_shift = {r_shift[DIGEST_W-9:0], 8'h00};
                  end else begin
                     w_next_shift = r_shift;
                  end
               end
            end else begin
               w_next_state = ST_WAIT_DONE;
            end
         end
         ST_FINISH: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Byte for the upcoming SEND, taken from the post-update shift/index
   always_comb begin
      w_enc_byte = 8'h00;
      if (w_next_idx == DIG_END) begin
         w_enc_byte = ASCII_CR;
      end else if (w_next_idx > DIG_END) begin
         w_enc_byte = ASCII_LF;
      end else if (HEX) begin
         if (w_next_idx[0]) begin
            w_enc_byte = nibble_to_hex(w_next_shift[DIGEST_W-5 -: 4]);
         end else begin
            w_enc_byte = nibble_to_hex(w_next_shift[DIGEST_W-1 -: 4]);
         end
      end else begin
         w_enc_byte = w_next_shift[DIGEST_W-1 -: 8];
      end
   end

   // State, datapath and registered outputs decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_idx      <= 7'd0;
         r_transmit <= 1'b0;
         r_tx_byte  <= 8'h00;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_shift    <= w_next_shift;
         r_idx      <= w_next_idx;
         r_transmit <= (w_next_state == ST_SEND);
         r_busy     <= (w_next_state == ST_SEND) || (w_next_state == ST_WAIT_BUSY) ||
                       (w_next_state == ST_WAIT_DONE);
         r_done     <= (w_next_state == ST_FINISH);
         if (w_next_state == ST_SEND) begin
            r_tx_byte <= w_enc_byte;
         end else begin
            r_tx_byte <= r_tx_byte;
         end
      end
   end

   assign transmit_o = r_transmit;
   assign tx_byte_o  = r_tx_byte;
   assign busy_o     = r_busy;
   assign done_o     = r_done;

endmodule

// File: tb/tb_digest_tx_serializer.sv
// uart_tx_model: UART transmitter stand-in. After each transmit strobe it
// raises is_transmitting_o lat_i cycles later (0 = on the strobe edge) and
// holds it for dur_i cycles. It has no reset, so a byte in flight survives a
// reset of the serializer.
module uart_tx_model (
   input  logic clk,
   input  logic transmit_i,
   input  int   lat_i,
   input  int   dur_i,
   output logic is_transmitting_o
);
   logic r_busy = 1'b0;
   logic r_pend = 1'b0;
   int   r_lat  = 0;
   int   r_dur  = 0;

   assign is_transmitting_o = r_busy;

   always @(posedge clk) begin
      if (transmit_i) begin
         if (lat_i == 0) begin
            r_busy <= 1'b1;
            r_dur  <= dur_i;
         end else begin
            r_pend <= 1'b1;
            r_lat  <= lat_i;
         end
      end else if (r_pend) begin
         if (r_lat <= 1) begin
            r_pend <= 1'b0;
            r_busy <= 1'b1;
            r_dur  <= dur_i;
         end else begin
            r_lat <= r_lat - 1;
         end
      end else if (r_busy) begin
         if (r_dur <= 1) begin
            r_busy <= 1'b0;
         end else begin
            r_dur <= r_dur - 1;
         end
      end
   end
endmodule

module tb_digest_tx_serializer;
   typedef logic [7:0] bq_t[$];

   localparam logic [255:0] ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n   = 1'b0;
   logic         start_h = 1'b0, start_r = 1'b0;
   logic [255:0] dig_h = '0, dig_r = '0;
   logic         is_tx_h, is_tx_r;
   logic         tx_h, tx_r, busy_h, busy_r, done_h, done_r;
   logic [7:0]   byte_h, byte_r;
   int           lat_h = 0, dur_h = 1, lat_r = 0, dur_r = 1;

   int  checks = 0, failures = 0;
   bq_t exp_h, exp_r;
   int  got_h = 0, got_r = 0, done_h_cnt = 0, done_r_cnt = 0;

   digest_tx_serializer #(.HEX_MODE(1), .APPEND_CRLF(1)) u_hex (
      .clk(clk), .rst_n(rst_n), .start_i(start_h), .digest_i(dig_h),
      .is_transmitting_i(is_tx_h), .transmit_o(tx_h), .tx_byte_o(byte_h),
      .busy_o(busy_h), .done_o(done_h));

   digest_tx_serializer #(.HEX_MODE(0), .APPEND_CRLF(0)) u_raw (
      .clk(clk), .rst_n(rst_n), .start_i(start_r), .digest_i(dig_r),
      .is_transmitting_i(is_tx_r), .transmit_o(tx_r), .tx_byte_o(byte_r),
      .busy_o(busy_r), .done_o(done_r));

   uart_tx_model u_uart_h (.clk(clk), .transmit_i(tx_h), .lat_i(lat_h), .dur_i(dur_h),
                           .is_transmitting_o(is_tx_h));
   uart_tx_model u_uart_r (.clk(clk), .transmit_i(tx_r), .lat_i(lat_r), .dur_i(dur_r),
                           .is_transmitting_o(is_tx_r));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
   endtask

   // Expected stream straight from the digest: hex text via string formatting,
   // raw bytes by slicing, then the optional line ending.
   function automatic bq_t build(input logic [255:0] d, input bit hex, input bit crlf);
      bq_t   q;
      string s;
      if (hex) begin
         s = $sformatf("%h", d);
         for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
      end else begin
         for (int i = 0; i < 32; i++) q.push_back(d[255 - 8*i -: 8]);
      end
      if (crlf) begin
         q.push_back(8'h0D);
         q.push_back(8'h0A);
      end
      return q;
   endfunction

   // Scoreboard: every strobe and done pulse of both instances
   always @(negedge clk) begin
      logic [7:0] e;
      if (tx_h) begin
         got_h++;
         chk("strobe_while_uart_busy_h", is_tx_h, 0);
         chk("busy_at_strobe_h", busy_h, 1);
         if (exp_h.size() == 0) fail("extra_byte_h");
         else begin
            e = exp_h.pop_front();
            chk($sformatf("byte_h[%0d]", got_h - 1), byte_h, e);
         end
         lat_h = $urandom_range(5, 0);
         dur_h = $urandom_range(20, 1);
      end
      if (done_h) begin
         done_h_cnt++;
         chk("done_with_bytes_left_h", exp_h.size(), 0);
         chk("busy_falls_with_done_h", busy_h, 0);
      end
      if (tx_r) begin
         got_r++;
         chk("strobe_while_uart_busy_r", is_tx_r, 0);
         chk("busy_at_strobe_r", busy_r, 1);
         if (exp_r.size() == 0) fail("extra_byte_r");
         else begin
            e = exp_r.pop_front();
            chk($sformatf("byte_r[%0d]", got_r - 1), byte_r, e);
         end
         lat_r = $urandom_range(5, 0);
         dur_r = $urandom_range(20, 1);
      end
      if (done_r) begin
         done_r_cnt++;
         chk("done_with_bytes_left_r", exp_r.size(), 0);
         chk("busy_falls_with_done_r", busy_r, 0);
      end
   end

   task automatic wait_uart_idle(input bit raw);
      int guard = 0;
      while ((raw ? is_tx_r : is_tx_h) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) fail("uart_idle_timeout");
   endtask

   // One full transfer; optional ignored start at byte pulse_at and on done
   task automatic run(input bit raw, input logic [255:0] d, input int pulse_at,
                      input bit pulse_done);
      int n     = raw ? 32 : 66;
      int guard = 0;
      bit pulsed = 1'b0;
      wait_uart_idle(raw);
      @(negedge clk); #1;
      if (raw) begin
         exp_r = build(d, 0, 0); got_r = 0; done_r_cnt = 0; dig_r = d; start_r = 1'b1;
      end else begin
         exp_h = build(d, 1, 1); got_h = 0; done_h_cnt = 0; dig_h = d; start_h = 1'b1;
      end
      @(posedge clk); #1;
      start_h = 1'b0; start_r = 1'b0;
      if (raw) dig_r = ~d; else dig_h = ~d;
      chk("busy_at_T+1", raw ? busy_r : busy_h, 1);
      chk("transmit_at_T+1", raw ? tx_r : tx_h, 1);
      while ((raw ? done_r_cnt : done_h_cnt) == 0 && guard < 20000) begin
         @(negedge clk); #1;
         guard++;
         if (pulse_at >= 0 && !pulsed && (raw ? got_r : got_h) == pulse_at) begin
            pulsed = 1'b1;
            if (raw) begin dig_r = d ^ {8{32'hA5A55A5A}}; start_r = 1'b1; end
            else     begin dig_h = d ^ {8{32'hA5A55A5A}}; start_h = 1'b1; end
            @(negedge clk); #1;
            start_h = 1'b0; start_r = 1'b0;
         end
      end
      if (guard >= 20000) fail("done_timeout");
      if (pulse_done) begin
         // still inside the done_o cycle: this start must be dropped
         if (raw) start_r = 1'b1; else start_h = 1'b1;
         @(negedge clk); #1;
         start_h = 1'b0; start_r = 1'b0;
      end
      repeat (10) @(negedge clk);
      #1;
      chk("done_pulse_count", raw ? done_r_cnt : done_h_cnt, 1);
      chk("byte_count", raw ? got_r : got_h, n);
      chk("idle_busy_after_done", raw ? busy_r : busy_h, 0);
   endtask

   initial begin
      bq_t q;
      int  guard;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_transmit_h", tx_h, 0);
      chk("rst_byte_h", byte_h, 8'h00);
      chk("rst_busy_h", busy_h, 0);
      chk("rst_done_h", done_h, 0);
      chk("rst_transmit_r", tx_r, 0);
      chk("rst_busy_r", busy_r, 0);
      rst_n = 1'b1;

      // pin the reference model against hand-derived bytes
      q = build(ABC, 1, 1);
      chk("model_hex_len", q.size(), 66);
      chk("model_hex_0", q[0], 8'h62);
      chk("model_hex_1", q[1], 8'h61);
      chk("model_hex_2", q[2], 8'h37);
      chk("model_hex_3", q[3], 8'h38);
      chk("model_hex_62", q[62], 8'h61);
      chk("model_hex_63", q[63], 8'h64);
      chk("model_hex_cr", q[64], 8'h0D);
      chk("model_hex_lf", q[65], 8'h0A);
      q = build(ABC, 0, 0);
      chk("model_raw_len", q.size(), 32);
      chk("model_raw_0", q[0], 8'hBA);
      chk("model_raw_1", q[1], 8'h78);
      chk("model_raw_3", q[3], 8'hBF);
      chk("model_raw_31", q[31], 8'hAD);

      // main transfers with ignored starts at byte 10 and on done
      run(1'b0, ABC, 10, 1'b1);
      run(1'b1, ABC, 10, 1'b1);

      // async reset while waiting for byte 20 to leave the UART
      wait_uart_idle(1'b0);
      @(negedge clk); #1;
      exp_h = build(ABC, 1, 1); got_h = 0; done_h_cnt = 0; dig_h = ABC; start_h = 1'b1;
      @(negedge clk); #1;
      start_h = 1'b0;
      guard = 0;
      while (!(got_h == 21 && is_tx_h) && guard < 5000) begin
         @(negedge clk); #1;
         guard++;
      end
      if (guard >= 5000) fail("reach_byte20_timeout");
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_transmit", tx_h, 0);
      chk("async_rst_byte", byte_h, 8'h00);
      chk("async_rst_busy", busy_h, 0);
      chk("async_rst_done", done_h, 0);
      chk("async_rst_idx", u_hex.r_idx, 0);
      chk("async_rst_shift_zero", (u_hex.r_shift == '0) ? 1 : 0, 1);
      exp_h.delete();
      @(negedge clk); #1;
      rst_n = 1'b1;
      run(1'b0, ABC, -1, 1'b0);

      // boundary digests
      run(1'b0, {256{1'b1}}, -1, 1'b0);
      chk("idx_end_ff", u_hex.r_idx, 65);
      run(1'b0, {256{1'b0}}, -1, 1'b0);
      chk("idx_end_00", u_hex.r_idx, 65);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
